// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, fill count and
// one-cycle overflow/underflow pulses.
module sync_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned AFULL_THR  = 12,
    parameter int unsigned AEMPTY_THR = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DW-1:0]            wr_data_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    input  logic                     rd_en_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     empty_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          wr_acc_c;
    logic          rd_acc_c;
    logic [CW-1:0] count_next_c;

    // Acceptance uses the registered flags; the next count drives the flags.
    always_comb begin
        wr_acc_c     = 1'b0;
        rd_acc_c     = 1'b0;
        count_next_c = count_o;
        wr_acc_c     = wr_en_i & ~full_o;
        rd_acc_c     = rd_en_i & ~empty_o;
        count_next_c = count_o + CW'(wr_acc_c) - CW'(rd_acc_c);
    end

    // Storage array is deliberately not reset so it maps onto a RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            rd_data_o      <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr    <= rd_ptr + AW'(1);
                rd_data_o <= mem[rd_ptr];
            end
            count_o        <= count_next_c;
            full_o         <= (count_next_c == CW'(DEPTH));
            empty_o        <= (count_next_c == '0);
            almost_full_o  <= (count_next_c >= CW'(AFULL_THR));
            almost_empty_o <= (count_next_c <= CW'(AEMPTY_THR));
            overflow_o     <= wr_en_i & full_o;
            underflow_o    <= rd_en_i & empty_o;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill/drain, wrap, boundary collisions,
// rate-limited traffic against a queue model, and asynchronous reset.
module tb_sync_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int passed;
    int total;
    logic [DW-1:0] q[$];

    sync_fifo #(
        .DEPTH(16), .DW(16), .AFULL_THR(12), .AEMPTY_THR(4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .empty_o        (empty),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model-gated random traffic; each accepted read is checked against the queue.
    task automatic run_rand(input int wpct, input int rpct);
        int txn;
        int cyc;
        int pulses;
        logic do_wr;
        logic do_rd;
        logic [DW-1:0] exp_d;
        txn    = 0;
        cyc    = 0;
        pulses = 0;
        while (txn < 1000 && cyc < 8000) begin
            do_wr   = (int'($urandom_range(99)) < wpct) && (q.size() < DEPTH);
            do_rd   = (int'($urandom_range(99)) < rpct) && (q.size() > 0);
            wr_en   = do_wr;
            rd_en   = do_rd;
            wr_data = DW'($urandom);
            tick();
            if (do_rd) begin
                exp_d = q.pop_front();
                chk("rand_rd_data", 32'(rd_data), 32'(exp_d));
                txn++;
            end
            if (do_wr) begin
                q.push_back(wr_data);
                txn++;
            end
            if (overflow || underflow) pulses++;
            cyc++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rand_txn_done", 32'(txn >= 1000), 32'(1));
        chk("rand_no_err_pulse", 32'(pulses), 32'(0));
        chk("rand_count", 32'(count), 32'(q.size()));
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #22;
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_aempty", 32'(almost_empty), 32'(1));
        chk("rst_afull", 32'(almost_full), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'h0000);
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_unf", 32'(underflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_empty", 32'(empty), 32'(1));

        // Fill 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(almost_full), 32'(i >= 12));
            chk("fill_full", 32'(full), 32'(i == 16));
            chk("fill_aempty", 32'(almost_empty), 32'(i <= 4));
            chk("fill_empty", 32'(empty), 32'(0));
        end
        wr_data = 16'hDEAD;
        tick();
        chk("ovf_pulse", 32'(overflow), 32'(1));
        chk("ovf_count", 32'(count), 32'(16));
        wr_en = 1'b0;
        tick();
        chk("ovf_drop", 32'(overflow), 32'(0));

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_data", 32'(rd_data), 32'(i));
            chk("drain_count", 32'(count), 32'(16 - i));
            chk("drain_empty", 32'(empty), 32'(i == 16));
        end
        tick();
        chk("unf_pulse", 32'(underflow), 32'(1));
        chk("unf_hold", 32'(rd_data), 32'h0010);
        rd_en = 1'b0;
        tick();
        chk("unf_drop", 32'(underflow), 32'(0));

        // Collision at empty: write taken, read rejected
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h0050;
        tick();
        chk("coll_empty_count", 32'(count), 32'(1));
        chk("coll_empty_unf", 32'(underflow), 32'(1));
        chk("coll_empty_hold", 32'(rd_data), 32'h0010);
        q.push_back(16'h0050);
        rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr_data = DW'(16'h0050 + i);
            tick();
            q.push_back(wr_data);
        end
        chk("pre_stream_count", 32'(count), 32'(5));

        // 40 cycles of simultaneous traffic at count 5
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = DW'(16'h0100 + i);
            tick();
            exp_d = q.pop_front();
            q.push_back(wr_data);
            chk("stream_data", 32'(rd_data), 32'(exp_d));
            chk("stream_count", 32'(count), 32'(5));
        end

        // Top up to full, then collide
        rd_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr_data = DW'(16'h0200 + i);
            tick();
            q.push_back(wr_data);
        end
        chk("topup_full", 32'(full), 32'(1));
        rd_en   = 1'b1;
        wr_data = 16'hBEEF;
        tick();
        exp_d = q.pop_front();
        chk("coll_full_count", 32'(count), 32'(15));
        chk("coll_full_ovf", 32'(overflow), 32'(1));
        chk("coll_full_data", 32'(rd_data), 32'(exp_d));
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();

        run_rand(70, 30);
        run_rand(30, 90);

        // Reach count 9, then reset asynchronously mid-burst
        rd_en = 1'b0;
        while (q.size() < 9) begin
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
            tick();
            q.push_back(wr_data);
        end
        wr_en = 1'b0;
        chk("pre_rst_count", 32'(count), 32'(9));
        wr_en   = 1'b1;
        wr_data = 16'h7777;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_full", 32'(full), 32'(0));
        chk("arst_aempty", 32'(almost_empty), 32'(1));
        chk("arst_afull", 32'(almost_full), 32'(0));
        chk("arst_rd_data", 32'(rd_data), 32'h0000);
        q.delete();
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'hA5A5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_data", 32'(rd_data), 32'hA5A5);
        chk("post_rst_empty", 32'(empty), 32'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parameterisable FIFO buffer that the FIFO stimulus/checker drives through its wr_en/wr_data/full and rd_en/rd_data/empty interface. It stores up to DEPTH words of DW bits. It provides registered status flags, programmable almost-full/almost-empty thresholds, a fill count, and one-cycle overflow/underflow error pulses for bench checking.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
DW, 16, data width in bits
AFULL_THR, 12, almost_full_o asserted when count >= AFULL_THR (1..DEPTH)
AEMPTY_THR, 4, almost_empty_o asserted when count <= AEMPTY_THR (0..DEPTH-1)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
wr_en_i  input  1  write request
wr_data_i  input  DW  write data
full_o  output  1  FIFO holds DEPTH words
almost_full_o  output  1  count >= AFULL_THR
rd_en_i  input  1  read request
rd_data_o  output  DW  read data, valid one cycle after accepted read
empty_o  output  1  FIFO holds 0 words
almost_empty_o  output  1  count <= AEMPTY_THR
count_o  output  $clog2(DEPTH)+1  current fill level 0..DEPTH
overflow_o  output  1  one-cycle pulse: write requested while full
underflow_o  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (rst_ni low, async): wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0 (AFULL_THR>=1), rd_data_o=0, overflow_o=0, underflow_o=0. Storage array is not reset. Deassertion is taken synchronously by the surrounding reset synchroniser; the block needs no extra logic for it.
- Write accept: wr_acc = wr_en_i & ~full_o, using the pre-edge full_o. On the edge, mem[wr_ptr] <= wr_data_i and wr_ptr increments.
- Read accept: rd_acc = rd_en_i & ~empty_o, using the pre-edge empty_o. On the edge, rd_data_o <= mem[rd_ptr] and rd_ptr increments. Read latency is 1 cycle. rd_data_o holds its value when no read is accepted.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count_next = count_o + wr_acc - rd_acc. All flags are registered and computed from count_next, so they are valid in the same cycle as count_o:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - almost_full = (count_next >= AFULL_THR)
  - almost_empty = (count_next <= AEMPTY_THR)
- Simultaneous wr/rd, 0 < count < DEPTH: both accepted, count unchanged, flags unchanged.
- Simultaneous wr/rd while full: read accepted, write rejected. count becomes DEPTH-1 and overflow_o pulses. Write-through-on-full is not supported.
- Simultaneous wr/rd while empty: write accepted, read rejected. count becomes 1, underflow_o pulses, and rd_data_o holds. There is no fall-through.
- overflow_o <= wr_en_i & full_o. underflow_o <= rd_en_i & empty_o. Each is high for exactly the cycle after the offending request.
- Rejected requests have no effect on memory, pointers, count, or rd_data_o.
- Reset asserted mid-operation: all state returns to reset values immediately, and stored data is discarded. The first read after reset returns the first word written after reset.
- Storage: inferred RAM with a synchronous write port and a registered read port. No read-during-write bypass is needed, because an entry can never be read and written in the same cycle unless count==0, and in that case the read is rejected.

Test Plan:
- Reset then idle → empty_o=1, full_o=0, count_o=0, almost_empty_o=1, rd_data_o=0x0000.
- Write 16 words 0x0001..0x0010 back-to-back → count_o steps 1..16; almost_full_o rises when count_o=12; full_o rises with count_o=16. A 17th write of 0xDEAD gives overflow_o=1 for one cycle, and count_o stays 16.
- Read 16 words from full → rd_data_o = 0x0001..0x0010 in order, each one cycle after its rd_en_i. empty_o rises with count_o=0. A 17th read gives underflow_o=1, and rd_data_o holds 0x0010.
- Simultaneous wr/rd every cycle for 40 cycles starting at count 5 (data 0x0100+i) → count_o stays 5, all pointers wrap, and the output sequence matches write order. Simultaneous wr/rd at empty → count_o=1, underflow_o=1. At full → count_o=15, overflow_o=1.
- Random rate stimulus via the FIFO stimulus/checker: 1000 transactions at write rate 0.7 and read rate 0.3, then at 0.3/0.9 → 0 data errors, and no overflow/underflow pulses.
- Assert rst_ni low mid-burst with count 9 (asynchronous, between edges) → all outputs take reset values without waiting for a clock edge. After release, write 0xA5A5 then read, and rd_data_o = 0xA5A5.
